// File: rtl/simd_mac_scheduler.sv
// simd_mac_scheduler: single-job sequencer for the SIMD multiprecision MAC.
// It accepts one job, clears the accumulator, streams the operand beats,
// waits out the pipeline latency, then holds the result until it is taken.
module simd_mac_scheduler #(
    parameter int unsigned LEN_W    = 8,
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [1:0]       job_mode,
    input  logic [LEN_W-1:0] job_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    input  logic [15:0]      op_c,
    output logic [1:0]       mac_sel,
    output logic             mac_clr,
    output logic             mac_en,
    output logic [15:0]      mac_a,
    output logic [15:0]      mac_b,
    output logic [15:0]      mac_c,
    input  logic [15:0]      mac_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic [1:0]       res_mode,
    output logic             res_err,
    output logic             busy
);

    localparam int unsigned DRAIN_W  = (PIPE_LAT == 0) ? 1 : $clog2(PIPE_LAT + 1);
    localparam logic [1:0]  MODE_ILL = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [LEN_W-1:0]   beat_cnt;
    logic [LEN_W-1:0]   beat_cnt_nx;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [DRAIN_W-1:0] drain_cnt_nx;
    logic               job_hs;
    logic               op_hs;
    logic               drain_last;

    // Status and handshake strobes decoded straight from the state register.
    assign job_ready  = (state == S_IDLE);
    assign op_ready   = (state == S_STREAM);
    assign res_valid  = (state == S_DONE);
    assign busy       = (state != S_IDLE);
    assign mac_clr    = (state == S_IDLE) || (state == S_CLEAR);
    assign job_hs     = job_valid && job_ready;
    assign op_hs      = op_valid && op_ready;
    assign drain_last = (state == S_DRAIN) && (drain_cnt == '0);

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nx;
            beat_cnt  <= beat_cnt_nx;
            drain_cnt <= drain_cnt_nx;
        end
    end

    // Next-state and counter update; the beat count is taken at acceptance
    // and tested in CLEAR so a zero-length job skips straight to DRAIN.
    always_comb begin
        state_nx     = state;
        beat_cnt_nx  = beat_cnt;
        drain_cnt_nx = drain_cnt;
        case (state)
            S_IDLE: begin
                if (job_hs) begin
                    state_nx    = S_CLEAR;
                    beat_cnt_nx = job_len;
                end
            end
            S_CLEAR: begin
                drain_cnt_nx = DRAIN_W'(PIPE_LAT);
                state_nx     = (beat_cnt == '0) ? S_DRAIN : S_STREAM;
            end
            S_STREAM: begin
                if (op_hs) begin
                    beat_cnt_nx = beat_cnt - LEN_W'(1);
                    if (beat_cnt == LEN_W'(1)) begin
                        state_nx = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nx = S_DONE;
                end else begin
                    drain_cnt_nx = drain_cnt - DRAIN_W'(1);
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath registers: mode select, operand staging, result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_sel  <= '0;
            mac_en   <= 1'b0;
            mac_a    <= '0;
            mac_b    <= '0;
            mac_c    <= '0;
            res_data <= '0;
            res_mode <= '0;
            res_err  <= 1'b0;
        end else begin
            if (job_hs) begin
                mac_sel <= job_mode;
            end
            // Illegal-mode beats are consumed but never reach the datapath.
            mac_en <= op_hs && (mac_sel != MODE_ILL);
            if (op_hs) begin
                mac_a <= op_a;
                mac_b <= op_b;
                mac_c <= op_c;
            end
            if (drain_last) begin
                res_data <= (mac_sel == MODE_ILL) ? 16'h0000 : mac_out;
                res_mode <= mac_sel;
                res_err  <= (mac_sel == MODE_ILL);
            end
        end
    end

endmodule

// File: tb/tb_simd_mac_scheduler.sv
// Directed bench for simd_mac_scheduler with a small behavioural MAC model.
module tb_simd_mac_scheduler;

    localparam int unsigned PL = 3;

    logic        clk;
    logic        rst_n;
    logic        job_valid;
    logic        job_ready;
    logic [1:0]  job_mode;
    logic [7:0]  job_len;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a, op_b, op_c;
    logic [1:0]  mac_sel;
    logic        mac_clr;
    logic        mac_en;
    logic [15:0] mac_a, mac_b, mac_c;
    logic [15:0] mac_out;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [1:0]  res_mode;
    logic        res_err;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic [15:0] vc [8];

    simd_mac_scheduler #(.LEN_W(8), .PIPE_LAT(PL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .job_valid (job_valid),
        .job_ready (job_ready),
        .job_mode  (job_mode),
        .job_len   (job_len),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_c      (op_c),
        .mac_sel   (mac_sel),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_c     (mac_c),
        .mac_out   (mac_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_mode  (res_mode),
        .res_err   (res_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub datapath: acc += (a^b)+c+sel per enabled beat, PL-stage output.
    logic [15:0] acc, p1, p2;
    always @(posedge clk) begin
        if (mac_clr) acc <= 16'h0000;
        else if (mac_en) acc <= acc + (mac_a ^ mac_b) + mac_c + {14'd0, mac_sel};
        p1 <= acc;
        p2 <= p1;
    end
    assign mac_out = p2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one job; lat is the cycle res_valid is seen, counted from
    // the acceptance cycle (CLEAR is cycle 1).
    task automatic run_job(input logic [1:0] mode, input logic [7:0] len,
                           input int gap_at, input int gap_len,
                           output int lat, output int en_n, output int en_first,
                           output int sel_bad, output int beats, output int ordy_bad);
        int   c;
        int   gapcnt;
        logic hs;
        en_n = 0; en_first = -1; sel_bad = 0; beats = 0; ordy_bad = 0; gapcnt = 0;
        job_mode = mode; job_len = len; job_valid = 1'b1;
        chk("job_ready_idle", 32'(job_ready), 32'd1);
        step();
        job_valid = 1'b0;
        c = 1;
        chk("clr_in_clear", 32'(mac_clr), 32'd1);
        chk("sel_at_accept", 32'(mac_sel), 32'(mode));
        while (!res_valid && c < 200) begin
            if (mac_en) begin
                en_n++;
                if (en_first < 0) en_first = c;
            end
            if (mac_sel !== mode) sel_bad++;
            if (op_ready && (c == 1 || beats >= int'(len))) ordy_bad++;
            if (mac_clr && c > 1) sel_bad++;
            if (gapcnt > 0) begin
                op_valid = 1'b0;
                gapcnt--;
            end else if (beats < int'(len)) begin
                op_valid = 1'b1;
                op_a = va[beats]; op_b = vb[beats]; op_c = vc[beats];
            end else begin
                op_valid = 1'b0;
            end
            hs = op_valid & op_ready;
            step();
            c++;
            if (hs) begin
                beats++;
                if (beats == gap_at) gapcnt = gap_len;
            end
        end
        op_valid = 1'b0;
        chk("res_valid_in_budget", 32'(res_valid), 32'd1);
        lat = c;
    endtask

    task automatic take_result(input logic [15:0] exp_data, input logic [1:0] exp_mode,
                               input logic exp_err, input int stall);
        chk("res_data", 32'(res_data), 32'(exp_data));
        chk("res_mode", 32'(res_mode), 32'(exp_mode));
        chk("res_err", 32'(res_err), 32'(exp_err));
        chk("busy_done", 32'(busy), 32'd1);
        chk("clr_done", 32'(mac_clr), 32'd0);
        for (int i = 0; i < stall; i++) begin
            job_valid = (i == 0);
            step();
            chk("res_hold_valid", 32'(res_valid), 32'd1);
            chk("res_hold_data", 32'(res_data), 32'(exp_data));
            chk("job_ready_in_done", 32'(job_ready), 32'd0);
        end
        job_valid = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("res_valid_after_take", 32'(res_valid), 32'd0);
        chk("job_ready_after_take", 32'(job_ready), 32'd1);
        chk("busy_after_take", 32'(busy), 32'd0);
        chk("clr_idle", 32'(mac_clr), 32'd1);
        chk("sel_held_idle", 32'(mac_sel), 32'(exp_mode));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, en_n, en_first, sel_bad, beats, ordy_bad, hold_bad;
        rst_n = 1'b0; job_valid = 1'b0; job_mode = 2'd0; job_len = 8'd0;
        op_valid = 1'b0; op_a = '0; op_b = '0; op_c = '0; res_ready = 1'b0;
        step();
        step();
        // Reset values.
        chk("rst_job_ready", 32'(job_ready), 32'd1);
        chk("rst_mac_clr", 32'(mac_clr), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_err", 32'(res_err), 32'd0);
        chk("rst_op_ready", 32'(op_ready), 32'd0);
        chk("rst_mac_en", 32'(mac_en), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_mac_sel", 32'(mac_sel), 32'd0);
        chk("rst_mac_abc", {mac_a, mac_b ^ mac_c}, 32'd0);
        chk("rst_res", {res_data, 14'd0, res_mode}, 32'd0);
        rst_n = 1'b1;
        step();

        // BF16 single beat, stalled consumer: 3F80^4000 = 7F80.
        va[0] = 16'h3F80; vb[0] = 16'h4000; vc[0] = 16'h0000;
        run_job(2'd0, 8'd1, -1, 0, lat, en_n, en_first, sel_bad, beats, ordy_bad);
        chk("bf16_lat", 32'(lat), 32'd7);
        chk("bf16_en_first", 32'(en_first), 32'd3);
        chk("bf16_en_n", 32'(en_n), 32'd1);
        chk("bf16_ordy", 32'(ordy_bad), 32'd0);
        take_result(16'h7F80, 2'd0, 1'b0, 4);

        // FP8, 4 beats, 2-cycle gap after beat 2: 7+6+18+8 = 39.
        va[0] = 16'h0001; vb[0] = 16'h0002; vc[0] = 16'h0003;
        va[1] = 16'h0004; vb[1] = 16'h0004; vc[1] = 16'h0005;
        va[2] = 16'h0010; vb[2] = 16'h0001; vc[2] = 16'h0000;
        va[3] = 16'h0000; vb[3] = 16'h0000; vc[3] = 16'h0007;
        run_job(2'd1, 8'd4, 2, 2, lat, en_n, en_first, sel_bad, beats, ordy_bad);
        chk("fp8_lat_gap", 32'(lat), 32'd12);
        chk("fp8_en_n", 32'(en_n), 32'd4);
        chk("fp8_sel_bad", 32'(sel_bad), 32'd0);
        chk("fp8_beats", 32'(beats), 32'd4);
        take_result(16'h0027, 2'd1, 1'b0, 0);

        // Mode switch: BF16 (result 1) then FP4 len 3: 5+2+3 = 10.
        va[0] = 16'h0001; vb[0] = 16'h0000; vc[0] = 16'h0000;
        run_job(2'd0, 8'd1, -1, 0, lat, en_n, en_first, sel_bad, beats, ordy_bad);
        chk("sw_bf16_lat", 32'(lat), 32'd7);
        take_result(16'h0001, 2'd0, 1'b0, 0);
        va[0] = 16'h0002; vb[0] = 16'h0001; vc[0] = 16'h0000;
        va[1] = 16'h0000; vb[1] = 16'h0000; vc[1] = 16'h0000;
        va[2] = 16'h0008; vb[2] = 16'h0008; vc[2] = 16'h0001;
        run_job(2'd2, 8'd3, -1, 0, lat, en_n, en_first, sel_bad, beats, ordy_bad);
        chk("fp4_lat", 32'(lat), 32'd9);
        chk("fp4_sel_bad", 32'(sel_bad), 32'd0);
        chk("fp4_en_n", 32'(en_n), 32'd3);
        take_result(16'h000A, 2'd2, 1'b0, 0);

        // Illegal mode: beats consumed, no mac_en, zero result with error.
        va[0] = 16'h1234; vb[0] = 16'h5678; vc[0] = 16'h9ABC;
        va[1] = 16'h1111; vb[1] = 16'h2222; vc[1] = 16'h3333;
        run_job(2'd3, 8'd2, -1, 0, lat, en_n, en_first, sel_bad, beats, ordy_bad);
        chk("ill_lat", 32'(lat), 32'd8);
        chk("ill_en_n", 32'(en_n), 32'd0);
        chk("ill_beats", 32'(beats), 32'd2);
        take_result(16'h0000, 2'd3, 1'b1, 0);

        // Zero length: no op_ready, res_valid at cycle 6.
        va[0] = 16'hFFFF; vb[0] = 16'h0000; vc[0] = 16'h0000;
        run_job(2'd0, 8'd0, -1, 0, lat, en_n, en_first, sel_bad, beats, ordy_bad);
        chk("zero_lat", 32'(lat), 32'd6);
        chk("zero_ordy", 32'(ordy_bad), 32'd0);
        chk("zero_beats", 32'(beats), 32'd0);
        take_result(16'h0000, 2'd0, 1'b0, 0);

        // Reset mid-job after 2 of 5 beats.
        va[0] = 16'h0101; vb[0] = 16'h0202; vc[0] = 16'h0303;
        job_mode = 2'd0; job_len = 8'd5; job_valid = 1'b1;
        step();
        job_valid = 1'b0;
        step();
        chk("mid_in_stream", 32'(op_ready), 32'd1);
        op_valid = 1'b1; op_a = va[0]; op_b = vb[0]; op_c = vc[0];
        step();
        step();
        op_valid = 1'b0;
        chk("mid_en_before_rst", 32'(mac_en), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_job_ready", 32'(job_ready), 32'd1);
        chk("arst_clr", 32'(mac_clr), 32'd1);
        chk("arst_op_ready", 32'(op_ready), 32'd0);
        chk("arst_mac_en", 32'(mac_en), 32'd0);
        chk("arst_mac_a", 32'(mac_a), 32'd0);
        chk("arst_res", {res_data, 13'd0, res_err, res_mode}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold_bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (res_valid !== 1'b0 || busy !== 1'b0) hold_bad++;
        end
        chk("post_rst_no_result", 32'(hold_bad), 32'd0);
        va[0] = 16'h0005; vb[0] = 16'h0003; vc[0] = 16'h0001;
        run_job(2'd1, 8'd1, -1, 0, lat, en_n, en_first, sel_bad, beats, ordy_bad);
        chk("post_rst_lat", 32'(lat), 32'd7);
        take_result(16'h0008, 2'd1, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/simd_mac_scheduler.md
# simd_mac_scheduler

Job sequencer for the SIMD multiprecision MAC datapath (BF16 / 2×FP8 / 4×FP4). It accepts one job at a time (precision mode + beat count) and drives the datapath's mode select and accumulator clear. It streams the job's operand beats into the MAC, waits out the pipeline latency, then captures and holds the packed result until the consumer takes it. It sits between the host/DMA front end and the MAC engine, replacing direct software control of `sel` and the per-lane resets.

## Interface
- `LEN_W`, 8: width of the job beat count.
- `PIPE_LAT`, 3: cycles from the MAC sampling an enabled beat to `mac_out` reflecting it.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `job_valid`  in  1  job request.
- `job_ready`  out  1  scheduler can accept a job.
- `job_mode`  in  2  0=BF16, 1=FP8×2, 2=FP4×4, 3=illegal.
- `job_len`  in  LEN_W  number of operand beats.
- `op_valid`  in  1  operand beat present.
- `op_ready`  out  1  scheduler accepts the beat.
- `op_a`, `op_b`, `op_c`  in  16 each  packed operands.
- `mac_sel`  out  2  datapath mode select.
- `mac_clr`  out  1  active-high accumulator clear to the datapath.
- `mac_en`  out  1  beat-valid strobe to the datapath.
- `mac_a`, `mac_b`, `mac_c`  out  16 each  registered operands.
- `mac_out`  in  16  datapath packed accumulator.
- `res_valid`  out  1  result present.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  16  captured result.
- `res_mode`  out  2  mode of the result.
- `res_err`  out  1  result is from an illegal-mode job.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **States:** IDLE → CLEAR → STREAM → DRAIN → DONE → IDLE.
- **IDLE**
  - `job_ready`=1 and `mac_clr`=1.
  - On `job_valid & job_ready`, latch mode and len, set `mac_sel`=mode, go to CLEAR.
- **CLEAR**
  - One cycle with `mac_clr`=1; load the beat counter with len.
  - len=0 goes directly to DRAIN; otherwise go to STREAM.
- **STREAM**
  - `op_ready`=1 and `mac_clr`=0.
  - Each handshake `op_valid & op_ready` registers op_a/b/c into mac_a/b/c and pulses `mac_en` the next cycle, then decrements the counter.
  - The handshake with the counter at 1 goes to DRAIN.
  - Gaps in `op_valid` stall without side effects; `mac_en` is 0 in gap cycles.
- **DRAIN**
  - Lasts exactly PIPE_LAT+1 cycles (down-counter).
  - At the end of the last DRAIN cycle, capture `mac_out` into `res_data`, latch `res_mode`, and set `res_err`=(mode==3). Go to DONE.
- **DONE**
  - `res_valid`=1; `res_data`, `res_mode` and `res_err` are held stable.
  - On `res_valid & res_ready`, go to IDLE.
- **Mode 3 (illegal)**
  - The job is accepted and its len beats are consumed normally, but `mac_en` stays 0.
  - `res_data`=16'h0000 and `res_err`=1.
- **`mac_sel`** changes only on job acceptance and holds its value through IDLE until the next job.
- **`mac_clr`** is 1 in IDLE and CLEAR and 0 in STREAM, DRAIN and DONE.
- **Reset:** assertion of `rst_n`=0 at any time, including mid-job, forces IDLE immediately. The partial job is discarded and no result is produced.

## Timing
- **Reset values:**
  - `job_ready`=1, `mac_clr`=1, `busy`=0, `res_err`=0.
  - `op_ready`, `mac_en` and `res_valid` are 0.
  - `mac_sel`, `mac_a`/`mac_b`/`mac_c`, `res_data` and `res_mode` are 0.
- **Latency:**
  - Job accepted in cycle T; CLEAR is cycle T+1; the first beat can be accepted in T+2.
  - If the last beat is accepted in cycle L, `mac_en` is high in L+1.
  - DRAIN occupies L+1…L+1+PIPE_LAT, and `res_valid` rises in cycle L+2+PIPE_LAT.
  - With back-to-back beats, `res_valid` rises at T+N+PIPE_LAT+3.
  - For len=0, `res_valid` rises at T+PIPE_LAT+3.
- **Job back-pressure:** `job_ready` returns in the cycle after the result handshake. This gives a minimum job-to-job gap of N+PIPE_LAT+4 cycles.
- **`op_ready`** is combinationally 0 outside STREAM. Beats offered early are not consumed.
- **Simultaneous events:** `job_valid` during DONE is ignored until IDLE. `res_ready` held high completes the handshake in the first DONE cycle.

## Test plan
- **BF16 single beat, stalled consumer:** mode=0, len=1, a=16'h3F80, b=16'h4000, c=16'h0000, PIPE_LAT=3, job at T=0 with `res_ready` held 0.
  - Expect CLEAR at 1, beat at 2, `mac_en` at 3, `res_valid` at 7.
  - `res_data` must equal the datapath model output and stay stable until `res_ready`; `res_err`=0.
- **FP8 with gaps:** mode=1, len=4, with `op_valid` deasserted for 2 cycles between beats 2 and 3.
  - Expect exactly 4 `mac_en` pulses, `mac_sel`=1 throughout the job, and the result delayed by exactly 2 cycles versus the back-to-back case.
- **Mode switch:** an FP4 job (mode=2, len=3) immediately after a BF16 job.
  - Expect `mac_clr`=1 in the CLEAR cycle and `mac_sel`=2 from acceptance onward.
  - Expect `res_mode`=2 and a result that does not depend on the prior BF16 accumulation.
- **Illegal mode:** mode=3, len=2.
  - Both beats are consumed, `mac_en` is never asserted, `res_data`=16'h0000 and `res_err`=1.
- **Zero length:** mode=0, len=0 accepted at T=0.
  - `op_ready` is never asserted and `res_valid` rises at cycle 6.
- **Reset mid-job:** assert `rst_n`=0 for 1 cycle during STREAM after 2 of 5 beats.
  - All outputs return to their reset values asynchronously and no result is produced.
  - A following job (mode=1, len=1) completes normally.
